// File: rtl/bepu_pkg.sv
// bepu_pkg: shared definitions for the BEPU scan unit.
//   SEG_TABLE   - active-low 7-segment patterns {dp,g,f,e,d,c,b,a}, dp off
//   SEG_BLANK   - all segments off
//   scan_state_e- digit scan state (dead / lit)
//   hex_to_seg  - nibble to segment pattern lookup
package bepu_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [7:0] SEG_TABLE [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  typedef enum logic {
    SCAN_DEAD = 1'b0,
    SCAN_LIT  = 1'b1
  } scan_state_e;

  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: digit scan timing for the multiplexed 7-segment display.
//   clk, rst  - clock, async active-high reset
//   an_o      - registered digit enables, active-low
//   idx_o     - current digit index
//   lit_o     - high when the current cycle drives a lit digit (not dead)
//
// state     | meaning
// SCAN_DEAD | one-clock anti-ghost gap after an index change, all digits off
// SCAN_LIT  | digit idx enabled
module seg_scan_ctrl
  import bepu_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [NUM_DIGITS-1:0] an_o,
  output logic [IDX_W-1:0]      idx_o,
  output logic                  lit_o
);

  localparam int PRE_W = $clog2(SCAN_DIV);

  logic [PRE_W-1:0]      pre_q, pre_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  scan_state_e           state_q, state_d;
  logic                  tc;

  assign tc = (pre_q == PRE_W'(SCAN_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q   <= '0;
      idx_q   <= '0;
      an_q    <= '1;
      state_q <= SCAN_DEAD;
    end else begin
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    pre_d   = tc ? '0 : pre_q + PRE_W'(1);
    idx_d   = idx_q;
    state_d = SCAN_LIT;
    an_d    = '1;
    if (tc) begin
      idx_d   = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
      state_d = SCAN_DEAD;
    end
    // Enables follow the state one clock later, so the dead state blanks
    // exactly the first cycle after each index change.
    if (state_q == SCAN_LIT) an_d[idx_q] = 1'b0;
  end

  assign an_o  = an_q;
  assign idx_o = idx_q;
  assign lit_o = (state_q == SCAN_LIT);

endmodule

// File: rtl/bepu_scan_unit.sv
// bepu_scan_unit: BEPU peripheral with bus-accessible LED and display
// registers, paged LED output and a scanned active-low 7-segment display.
//   clk, rst            - clock, async active-high reset
//   sel_led, sel_seg    - bus selects (display register has read priority)
//   bus_w, bus_wdata    - write strobe and data
//   bus_rdata           - registered read data, 1-cycle latency
//   led_page            - LED slice select
//   led_data            - registered LED slice, active-high
//   segment_data, AN    - registered segment pattern and digit enables
// Optional build macro BEPU_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module bepu_scan_unit
  import bepu_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int LED_WIDTH  = 8,
  parameter int SCAN_DIV   = 50000,
  parameter int PAGE_W     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sel_led,
  input  logic                  sel_seg,
  input  logic                  bus_w,
  input  logic [31:0]           bus_wdata,
  output logic [31:0]           bus_rdata,
  input  logic [PAGE_W-1:0]     led_page,
  output logic [LED_WIDTH-1:0]  led_data,
  output logic [7:0]            segment_data,
  output logic [NUM_DIGITS-1:0] AN
);

  localparam int PAGES = 32 / LED_WIDTH;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [31:0]          led_reg_q, seg_reg_q, rdata_q, rdata_d;
  logic [LED_WIDTH-1:0] led_q, led_d;
  logic [7:0]           segment_q, segment_d;
  logic [31:0]          led_shift, nib_shift;
  logic [IDX_W-1:0]     idx;
  logic                 lit;
  logic                 lz_blank;

  seg_scan_ctrl #(
    .NUM_DIGITS(NUM_DIGITS),
    .SCAN_DIV  (SCAN_DIV),
    .IDX_W     (IDX_W)
  ) u_scan (
    .clk  (clk),
    .rst  (rst),
    .an_o (AN),
    .idx_o(idx),
    .lit_o(lit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_reg_q <= '0;
      seg_reg_q <= '0;
      rdata_q   <= '0;
      led_q     <= '0;
      segment_q <= SEG_BLANK;
    end else begin
      if (bus_w && sel_led) led_reg_q <= bus_wdata;
      if (bus_w && sel_seg) seg_reg_q <= bus_wdata;
      rdata_q   <= rdata_d;
      led_q     <= led_d;
      segment_q <= segment_d;
    end
  end

  // Read mux samples the pre-write register contents.
  always_comb begin
    rdata_d = '0;
    if (sel_seg)      rdata_d = seg_reg_q;
    else if (sel_led) rdata_d = led_reg_q;
  end

  assign led_shift = led_reg_q >> (32'(led_page) * 32'(LED_WIDTH));
  assign led_d     = (32'(led_page) < 32'(PAGES)) ? led_shift[LED_WIDTH-1:0] : '0;

  assign nib_shift = seg_reg_q >> {idx, 2'b00};

`ifdef BEPU_LEADING_ZERO_BLANK_EN
  // Blank digit idx when it and every higher displayed nibble are zero.
  always_comb begin
    lz_blank = (idx != '0);
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (j >= int'(idx) && seg_reg_q[j*4 +: 4] != 4'h0) lz_blank = 1'b0;
    end
  end
`else
  assign lz_blank = 1'b0;
`endif

  assign segment_d = (!lit || lz_blank) ? SEG_BLANK : hex_to_seg(nib_shift[3:0]);

  assign bus_rdata    = rdata_q;
  assign led_data     = led_q;
  assign segment_data = segment_q;

endmodule
